// File: rtl/dct_pkg.sv
// Shared definitions for the N-point DCT MAC engine: FSM states and the
// Q.4 coefficient ROMs for the 4- and 8-point transforms.
package dct_pkg;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    localparam int ROM_FRAC_W = 4;

    // Row k, column n holds round(16 * c_k * cos((2n+1)k*pi/2N)).
    localparam int COEF4 [4][4] = '{
        '{ 8,   8,   8,   8},
        '{10,   4,  -4, -10},
        '{ 8,  -8,  -8,   8},
        '{ 4, -10,  10,  -4}
    };

    localparam int COEF8 [8][8] = '{
        '{6,  6,  6,  6,  6,  6,  6,  6},
        '{8,  7,  4,  2, -2, -4, -7, -8},
        '{7,  3, -3, -7, -7, -3,  3,  7},
        '{7, -2, -8, -4,  4,  8,  2, -7},
        '{6, -6, -6,  6,  6, -6, -6,  6},
        '{4, -8,  2,  7, -7, -2,  8, -4},
        '{3, -7,  7, -3, -3,  7, -7,  3},
        '{2, -4,  7, -8,  8, -7,  4, -2}
    };

    function automatic int coef(input int n, input int row, input int col);
        if (n == 8) return COEF8[row % 8][col % 8];
        return COEF4[row % 4][col % 4];
    endfunction

endpackage

// File: rtl/dct_mac_lane.sv
// One signed multiply-accumulate lane; sum is the accumulator value that the
// current product would produce, so the top can capture the final result.
module dct_mac_lane #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 18
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [OUT_W-1:0]  sum
);

    logic signed [DATA_W+COEF_W-1:0] prod;
    logic signed [OUT_W-1:0]         acc;

    assign prod = sample * coef;
    assign sum  = acc + OUT_W'(prod);

    always_ff @(posedge clk) begin
        if (clr)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/dct_npoint_mac.sv
// Sequential N-point forward/inverse DCT: one block in, N MAC cycles across
// N parallel lanes, one full-precision block out with valid/ready handshakes.
module dct_npoint_mac
    import dct_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int FRAC_W = 4,
    parameter int OUT_W  = DATA_W + COEF_W + $clog2(N)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_mode,
    input  logic [N*DATA_W-1:0]   i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [N*OUT_W-1:0]    o_data,
    output logic                  o_busy
);

    localparam int CNT_W = $clog2(N);

    if ((N != 4 && N != 8) || FRAC_W != ROM_FRAC_W) begin : g_param_check
        $error("dct_npoint_mac: unsupported N or FRAC_W");
    end

    state_t                   state, state_n;
    logic [CNT_W-1:0]         cnt;
    logic                     mode;
    logic                     accept, last, calc;
    logic signed [DATA_W-1:0] x_q       [N];
    logic signed [COEF_W-1:0] lane_coef [N];
    logic signed [OUT_W-1:0]  lane_sum  [N];
    logic signed [OUT_W-1:0]  out_q     [N];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        o_ready = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_n = CALC;
            end
            CALC: begin
                if (last) state_n = HOLD;
            end
            HOLD: begin
                o_ready = i_ready;
                if (i_ready) state_n = i_valid ? CALC : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign accept  = i_valid && o_ready;
    assign calc    = (state == CALC);
    assign last    = calc && (cnt == CNT_W'(N - 1));
    assign o_valid = (state == HOLD);
    assign o_busy  = calc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt  <= '0;
            mode <= 1'b0;
            for (int j = 0; j < N; j++) out_q[j] <= '0;
        end else begin
            if (accept) begin
                cnt  <= '0;
                mode <= i_mode;
            end else if (calc) begin
                cnt <= cnt + CNT_W'(1);
            end
            // Result register only moves on the final MAC edge.
            if (last) begin
                for (int j = 0; j < N; j++) out_q[j] <= lane_sum[j];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int j = 0; j < N; j++) x_q[j] <= i_data[j*DATA_W +: DATA_W];
        end
    end

    // Forward uses row j of the ROM, inverse uses column j.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            lane_coef[j] = mode ? COEF_W'(coef(N, int'(cnt), j))
                                : COEF_W'(coef(N, j, int'(cnt)));
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        dct_mac_lane #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .OUT_W  (OUT_W)
        ) u_lane (
            .clk    (i_clk),
            .clr    (accept),
            .en     (calc),
            .sample (x_q[cnt]),
            .coef   (lane_coef[j]),
            .sum    (lane_sum[j])
        );

        assign o_data[j*OUT_W +: OUT_W] = out_q[j];
    end

endmodule

// File: tb/tb_dct_npoint_mac.sv
// Scoreboard bench: directed 4-point cases plus randomized 8-point blocks
// compared against a floating-point-derived DCT reference.
module tb_dct_npoint_mac;

    localparam int DW  = 8;
    localparam int OW4 = 18;
    localparam int OW8 = 19;
    localparam int VW  = 8 * OW8;
    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic rst_n;

    logic              valid4, mode4, ready4, rdy4, ovld4, busy4;
    logic [4*DW-1:0]   data4;
    logic [4*OW4-1:0]  out4;
    logic              valid8, mode8, ready8, rdy8, ovld8, busy8;
    logic [8*DW-1:0]   data8;
    logic [8*OW8-1:0]  out8;

    logic [4*OW4-1:0]  q4[$];
    logic [8*OW8-1:0]  q8[$];
    int checks = 0;
    int failures = 0;
    bit rand_phase = 1'b0;

    always #5 clk = ~clk;

    dct_npoint_mac #(.N(4), .DATA_W(8), .COEF_W(8), .FRAC_W(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid4), .o_ready(rdy4),
        .i_mode(mode4), .i_data(data4), .o_valid(ovld4), .i_ready(ready4),
        .o_data(out4), .o_busy(busy4)
    );

    dct_npoint_mac #(.N(8), .DATA_W(8), .COEF_W(8), .FRAC_W(4)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid8), .o_ready(rdy8),
        .i_mode(mode8), .i_data(data8), .o_valid(ovld8), .i_ready(ready8),
        .o_data(out8), .o_busy(busy8)
    );

    function automatic int ref_coef(input int n, input int k, input int i);
        real ck, v;
        ck = (k == 0) ? $sqrt(1.0 / n) : $sqrt(2.0 / n);
        v  = 16.0 * ck * $cos((2 * i + 1) * k * PI / (2.0 * n));
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic void ref_dct(input int n, input int x[8], input logic md,
                                    output longint y[8]);
        for (int o = 0; o < 8; o++) begin
            y[o] = 0;
            if (o < n) begin
                for (int i = 0; i < n; i++)
                    y[o] += md ? ref_coef(n, i, o) * x[i] : ref_coef(n, o, i) * x[i];
            end
        end
    endfunction

    function automatic logic [4*OW4-1:0] exp4(input int x[8], input logic md);
        longint y[8];
        logic [4*OW4-1:0] r;
        ref_dct(4, x, md, y);
        for (int k = 0; k < 4; k++) r[k*OW4 +: OW4] = OW4'(y[k]);
        return r;
    endfunction

    function automatic logic [8*OW8-1:0] exp8(input int x[8], input logic md);
        longint y[8];
        logic [8*OW8-1:0] r;
        ref_dct(8, x, md, y);
        for (int k = 0; k < 8; k++) r[k*OW8 +: OW8] = OW8'(y[k]);
        return r;
    endfunction

    function automatic logic [4*OW4-1:0] pack_out4(input int a, input int b,
                                                   input int c, input int d);
        logic [4*OW4-1:0] r;
        r[0*OW4 +: OW4] = OW4'(a);
        r[1*OW4 +: OW4] = OW4'(b);
        r[2*OW4 +: OW4] = OW4'(c);
        r[3*OW4 +: OW4] = OW4'(d);
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_vec(input string name, input logic [VW-1:0] act,
                           input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Present a block to the 4-point engine; returns cycles until accept (0 = timeout).
    task automatic issue4(input int x[8], input logic md, input bit push, output int waited);
        for (int i = 0; i < 4; i++) data4[i*DW +: DW] = DW'(x[i]);
        mode4  = md;
        valid4 = 1'b1;
        waited = 0;
        for (int c = 1; c <= 50 && waited == 0; c++) begin
            @(negedge clk);
            if (rdy4) begin
                waited = c;
                if (push) q4.push_back(exp4(x, md));
            end
            @(posedge clk);
            #1;
        end
        valid4 = 1'b0;
        mode4  = ~md;
        data4  = DW*4'($urandom);
        if (waited == 0) chk("accept4_timeout", 0, 1);
    endtask

    task automatic wait_valid4(output int lat);
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            if (ovld4) lat = c;
        end
    endtask

    task automatic run4(input string name, input int x[8], input logic md,
                        input int e0, input int e1, input int e2, input int e3);
        int w, lat;
        issue4(x, md, 1'b1, w);
        wait_valid4(lat);
        chk({name, "_latency"}, lat, 4);
        chk_vec({name, "_const"}, VW'(out4), VW'(pack_out4(e0, e1, e2, e3)));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ovld4) begin
            if (q4.size() == 0) begin
                chk("spurious_valid4", 1, 0);
            end else if (ready4) begin
                chk_vec("scoreboard4", VW'(out4), VW'(q4.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (ovld8) begin
            if (q8.size() == 0) begin
                chk("spurious_valid8", 1, 0);
            end else if (ready8) begin
                chk_vec("scoreboard8", out8, q8.pop_front());
            end
        end
    end

    initial begin
        ready8 = 1'b0;
        wait (rand_phase);
        while (rand_phase) begin
            @(posedge clk);
            #1;
            ready8 = ($urandom_range(0, 3) != 0);
        end
        ready8 = 1'b1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v[8];
        int w, lat;
        logic [4*OW4-1:0] saved;

        rst_n = 1'b0;
        valid4 = 1'b0; mode4 = 1'b0; ready4 = 1'b0; data4 = '0;
        valid8 = 1'b0; mode8 = 1'b0; data8 = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_ready4", rdy4, 1);
        chk("reset_valid4", ovld4, 0);
        chk("reset_busy4", busy4, 0);
        chk_vec("reset_data4", VW'(out4), '0);
        chk("reset_valid8", ovld8, 0);

        ready4 = 1'b1;
        v = '{10, 10, 10, 10, 0, 0, 0, 0};
        run4("fwd_dc", v, 1'b0, 320, 0, 0, 0);
        v = '{1, 0, 0, 0, 0, 0, 0, 0};
        run4("fwd_impulse", v, 1'b0, 8, 10, 8, 4);
        v = '{-128, 0, 0, 0, 0, 0, 0, 0};
        run4("fwd_neg_impulse", v, 1'b0, -1024, -1280, -1024, -512);
        v = '{1, 0, 0, 0, 0, 0, 0, 0};
        run4("inv_impulse0", v, 1'b1, 8, 8, 8, 8);
        v = '{0, 1, 0, 0, 0, 0, 0, 0};
        run4("inv_impulse1", v, 1'b1, 10, 4, -4, -10);

        // Backpressure in HOLD, then back-to-back accept on the releasing edge.
        ready4 = 1'b0;
        v = '{3, -5, 7, 100, 0, 0, 0, 0};
        issue4(v, 1'b0, 1'b1, w);
        wait_valid4(lat);
        chk("bp_latency", lat, 4);
        saved = out4;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid_held", ovld4, 1);
            chk_vec("bp_data_held", VW'(out4), VW'(saved));
            chk("bp_ready_low", rdy4, 0);
        end
        @(posedge clk);
        #1;
        ready4 = 1'b1;
        v = '{-7, 20, 0, -3, 0, 0, 0, 0};
        issue4(v, 1'b1, 1'b1, w);
        chk("b2b_accept_wait", w, 1);
        wait_valid4(lat);
        chk("b2b_latency", lat, 4);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a calculation.
        v = '{50, -60, 70, -80, 0, 0, 0, 0};
        issue4(v, 1'b0, 1'b0, w);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("abort_busy_before", busy4, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", ovld4, 0);
        chk("abort_busy", busy4, 0);
        chk_vec("abort_data", VW'(out4), '0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_ready", rdy4, 1);
        chk("post_reset_valid", ovld4, 0);
        v = '{1, 2, 3, 4, 0, 0, 0, 0};
        run4("post_reset_fwd", v, 1'b0, 80, -34, 0, -2);

        // Randomized 8-point blocks in both modes with random flow control.
        rand_phase = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            int x[8];
            logic md;
            int ok;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < 8; i++) begin
                x[i] = int'($urandom_range(0, 255)) - 128;
                data8[i*DW +: DW] = DW'(x[i]);
            end
            md = 1'($urandom);
            mode8  = md;
            valid8 = 1'b1;
            ok = 0;
            for (int c = 0; c < 200 && ok == 0; c++) begin
                @(negedge clk);
                if (rdy8) begin
                    ok = 1;
                    q8.push_back(exp8(x, md));
                end
                @(posedge clk);
                #1;
            end
            valid8 = 1'b0;
            mode8  = 1'($urandom);
            data8  = {$urandom, $urandom};
            if (ok == 0) begin
                chk("accept8_timeout", 0, 1);
                break;
            end
        end
        rand_phase = 1'b0;
        for (int c = 0; c < 500 && q8.size() > 0; c++) @(posedge clk);
        @(negedge clk);
        chk("drain8", q8.size(), 0);
        chk("drain4", q4.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dct_npoint_mac.md
# dct_npoint_mac

Parametrised N-point 1-D DCT engine. It is the sequential successor of the combinational 4-point matrix-multiply DCT. N signed input samples arrive in one valid/ready transfer. N parallel MAC lanes process them over N cycles against a fixed Q-format coefficient ROM, and the N full-precision results are presented in one valid/ready transfer. A per-block mode selects forward DCT or inverse DCT (transposed matrix). The block sits between the pixel/row buffer and the quantiser, and is reused for the column pass.

## Interface
Parameters:
- N, 4: transform size; legal values 4 and 8.
- DATA_W, 8: input sample width, signed two's complement.
- COEF_W, 8: coefficient width, signed, Q(COEF_W-FRAC_W).FRAC_W.
- FRAC_W, 4: coefficient fraction bits (0.5 = 8).
- OUT_W, DATA_W+COEF_W+$clog2(N): output width per lane, full precision, no rounding.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  reset; **asynchronous, active-low**.
- i_valid  in  1  input block valid.
- o_ready  out  1  block can accept input.
- i_mode  in  1  0 = forward DCT, 1 = inverse DCT; sampled on input handshake.
- i_data  in  N*DATA_W  sample n at bits [n*DATA_W +: DATA_W].
- o_valid  out  1  result block valid.
- i_ready  in  1  downstream accepts result.
- o_data  out  N*OUT_W  coefficient k at bits [k*OUT_W +: OUT_W].
- o_busy  out  1  high in CALC.

## Operation
- Coefficient C[k][n] = round(2^FRAC_W · c_k · cos((2n+1)kπ/2N)), with c_0 = √(1/N) and c_k = √(2/N).
  - N=4 rows: [8,8,8,8], [10,4,-4,-10], [8,-8,-8,8], [4,-10,10,-4].
- Forward: y[k] = Σ_n C[k][n]·x[n]. Inverse: y[n] = Σ_k C[k][n]·x[k]; lane j uses column j.
- Products are signed DATA_W×COEF_W. Accumulation is sign-extended to OUT_W, which cannot overflow.
- FSM states:
  - IDLE:
    - o_ready=1.
    - On i_valid: latch i_data and i_mode, clear all accumulators, set cnt=0, go to CALC.
  - CALC:
    - o_ready=0.
    - Each cycle, every lane j adds coef(j,cnt)·x[cnt], then cnt++.
    - After the MAC with cnt=N-1: go to HOLD with o_valid=1.
  - HOLD:
    - o_valid=1 and o_data stable until i_ready.
    - i_ready without i_valid: go to IDLE.
    - i_ready with i_valid: back-to-back; latch new block and go to CALC. o_ready = i_ready in HOLD, combinational.
- i_valid with o_ready=0 is ignored; the source must hold it.
- Reset values: FSM=IDLE, o_valid=0, o_busy=0, o_data=0, cnt=0, latched mode=0. o_ready=1 once reset releases.
- Reset asserted mid-CALC or mid-HOLD aborts the block. No partial output is ever flagged valid.

## Timing
- Latency: accept edge E0; MACs on edges E1..EN. o_valid is high after EN, so N cycles from accept to valid.
- Throughput: one block per N+1 cycles with i_ready held high. HOLD lasts at least one cycle.
- o_data is registered and changes only on the edge that leaves CALC. It is constant while o_valid=1.
- The mode of a block is fixed at its accept edge. Changing i_mode later has no effect on that block.
- No combinational path from i_data to o_data. o_ready depends combinationally on i_ready only in HOLD.

## Structure
- Package dct_pkg:
  - Coefficient ROMs for N=4 and N=8 as localparam arrays.
  - Function coef(N, row, col).
  - FSM state enum (IDLE, CALC, HOLD).
- Sub-module dct_mac_lane: one signed MAC with clear and enable, instantiated N times via generate. It receives coefficient and sample from the top-level mux on cnt and mode.
- Top level holds the FSM, counter, input register and handshake logic.

## Test plan
- N=4, forward, x=[10,10,10,10] -> o_data=[320,0,0,0]; o_valid exactly 4 cycles after accept.
- N=4, forward, impulse x=[1,0,0,0] -> [8,10,8,4]. Same with x=[-128,0,0,0] -> [-1024,-1280,-1024,-512], checking sign extension at OUT_W=18.
- N=4, inverse, x=[1,0,0,0] -> [8,8,8,8]. Then X=[0,1,0,0] -> [10,4,-4,-10].
- Backpressure: i_ready low for 5 cycles in HOLD -> o_data/o_valid stable, o_ready=0. Then i_ready with i_valid -> new block accepted the same edge; next result after 4 more cycles.
- Reset: assert i_rst_n=0 asynchronously at cnt=2 -> o_valid, o_data and o_busy go to 0 immediately. After release o_ready=1 and the next block computes correctly.
- N=8 random vectors against a bit-accurate reference model, both modes, 1000 blocks, random i_valid/i_ready.
